// File: rtl/data_cache_controller_pkg.sv
// rtl/data_cache_controller_pkg.sv - shared constants, state encoding and address-split helpers
package data_cache_controller_pkg;

  localparam int WORD_SIZE  = 16;
  localparam int LINE_WORDS = 4;
  localparam int OFFSET_W   = 2;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FILL,
    RESP
  } state_t;

  function automatic int index_width(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_width(input int word_size, input int lines);
    return word_size - OFFSET_W - $clog2(lines);
  endfunction

endpackage

// File: rtl/data_cache_controller_line_store.sv
// rtl/data_cache_controller_line_store.sv - valid/dirty/tag/data arrays with combinational lookup
module cache_line_store #(
  parameter int WORD_SIZE = data_cache_controller_pkg::WORD_SIZE,
  parameter int LINES     = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic [data_cache_controller_pkg::index_width(LINES)-1:0] index,
  input  logic [data_cache_controller_pkg::tag_width(WORD_SIZE, LINES)-1:0] tag,
  output logic hit,
  output logic victim_valid,
  output logic victim_dirty,
  output logic [data_cache_controller_pkg::tag_width(WORD_SIZE, LINES)-1:0] victim_tag,
  output logic [data_cache_controller_pkg::LINE_WORDS*WORD_SIZE-1:0] victim_line,
  input  logic line_we,
  input  logic line_dirty,
  input  logic [data_cache_controller_pkg::LINE_WORDS*WORD_SIZE-1:0] line_data,
  input  logic word_we,
  input  logic [data_cache_controller_pkg::OFFSET_W-1:0] word_offset,
  input  logic [WORD_SIZE-1:0] word_data
);
  import data_cache_controller_pkg::*;

  localparam int TW = tag_width(WORD_SIZE, LINES);
  localparam int LW = LINE_WORDS * WORD_SIZE;

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic [TW-1:0]    tag_q  [LINES];
  logic [LW-1:0]    data_q [LINES];

  assign victim_valid = valid_q[index];
  assign victim_dirty = dirty_q[index];
  assign victim_tag   = tag_q[index];
  assign victim_line  = data_q[index];
  assign hit          = valid_q[index] && (tag_q[index] == tag);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= line_dirty;
    end else if (word_we) begin
      dirty_q[index] <= 1'b1;
    end
  end

  // Tag and data need no reset: they are ignored while the valid bit is clear.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[index]  <= tag;
      data_q[index] <= line_data;
    end else if (word_we) begin
      data_q[index][int'(word_offset)*WORD_SIZE +: WORD_SIZE] <= word_data;
    end
  end

endmodule

// File: rtl/data_cache_controller.sv
// rtl/data_cache_controller.sv - direct-mapped write-back data cache FSM with hit/miss statistics
module data_cache_controller #(
  parameter int WORD_SIZE   = data_cache_controller_pkg::WORD_SIZE,
  parameter int LINES       = 8,
  parameter int MEM_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [WORD_SIZE-1:0]   cpu_addr,
  input  logic [WORD_SIZE-1:0]   cpu_wdata,
  output logic [WORD_SIZE-1:0]   cpu_rdata,
  output logic                   cpu_ready,
  output logic                   readM,
  output logic                   writeM,
  output logic [WORD_SIZE-1:0]   address,
  input  logic [4*WORD_SIZE-1:0] mem_rdata,
  output logic [4*WORD_SIZE-1:0] mem_wdata,
  output logic [15:0]            hit_count,
  output logic [15:0]            miss_count
);
  import data_cache_controller_pkg::*;

  localparam int IW = index_width(LINES);
  localparam int TW = tag_width(WORD_SIZE, LINES);
  localparam int LW = LINE_WORDS * WORD_SIZE;
  localparam int CW = $clog2(MEM_LATENCY + 1);

  state_t        state, next_state;
  logic [CW-1:0] cnt;

  logic [IW-1:0]       req_index;
  logic [TW-1:0]       req_tag;
  logic [OFFSET_W-1:0] req_offset;

  logic          hit, victim_valid, victim_dirty;
  logic [TW-1:0] victim_tag;
  logic [LW-1:0] victim_line;
  logic [LW-1:0] fill_line;

  logic xfer_done, idle_hit, idle_miss, fill_done;

  assign req_offset = cpu_addr[OFFSET_W-1:0];
  assign req_index  = cpu_addr[OFFSET_W +: IW];
  assign req_tag    = cpu_addr[WORD_SIZE-1 -: TW];

  assign xfer_done = (cnt == CW'(MEM_LATENCY - 1));
  assign idle_hit  = (state == IDLE) && cpu_req && hit;
  assign idle_miss = (state == IDLE) && cpu_req && !hit;
  assign fill_done = (state == FILL) && xfer_done;
  assign mem_wdata = victim_line;

  // A store miss merges the CPU word into the incoming line before it is written.
  always_comb begin
    fill_line = mem_rdata;
    if (cpu_we) fill_line[int'(req_offset)*WORD_SIZE +: WORD_SIZE] = cpu_wdata;
  end

  cache_line_store #(
    .WORD_SIZE (WORD_SIZE),
    .LINES     (LINES)
  ) u_store (
    .clk          (clk),
    .reset_n      (reset_n),
    .index        (req_index),
    .tag          (req_tag),
    .hit          (hit),
    .victim_valid (victim_valid),
    .victim_dirty (victim_dirty),
    .victim_tag   (victim_tag),
    .victim_line  (victim_line),
    .line_we      (fill_done),
    .line_dirty   (cpu_we),
    .line_data    (fill_line),
    .word_we      (idle_hit && cpu_we),
    .word_offset  (req_offset),
    .word_data    (cpu_wdata)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      if ((state == WRITEBACK || state == FILL) && !xfer_done) cnt <= cnt + CW'(1);
      else                                                     cnt <= '0;
    end
  end

  always_comb begin
    next_state = state;
    readM      = 1'b0;
    writeM     = 1'b0;
    cpu_ready  = 1'b0;
    address    = '0;
    case (state)
      IDLE: begin
        if (idle_hit)                                 next_state = RESP;
        else if (idle_miss && victim_valid && victim_dirty) next_state = WRITEBACK;
        else if (idle_miss)                           next_state = FILL;
      end
      WRITEBACK: begin
        writeM  = 1'b1;
        address = {victim_tag, req_index, 2'b00};
        if (xfer_done) next_state = FILL;
      end
      FILL: begin
        readM   = 1'b1;
        address = {req_tag, req_index, 2'b00};
        if (xfer_done) next_state = RESP;
      end
      RESP: begin
        cpu_ready  = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cpu_rdata  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (idle_hit && !cpu_we)
        cpu_rdata <= victim_line[int'(req_offset)*WORD_SIZE +: WORD_SIZE];
      else if (fill_done && !cpu_we)
        cpu_rdata <= mem_rdata[int'(req_offset)*WORD_SIZE +: WORD_SIZE];
      if (idle_hit && hit_count != 16'hFFFF)   hit_count  <= hit_count + 16'd1;
      if (idle_miss && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_data_cache_controller.sv
// tb/tb_data_cache_controller.sv - directed vector bench for data_cache_controller
module tb_data_cache_controller;

  logic        clk, reset_n;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ready, readM, writeM;
  logic [15:0] address;
  logic [63:0] mem_rdata, mem_wdata;
  logic [15:0] hit_count, miss_count;

  data_cache_controller #(
    .WORD_SIZE   (16),
    .LINES       (8),
    .MEM_LATENCY (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ready  (cpu_ready),
    .readM      (readM),
    .writeM     (writeM),
    .address    (address),
    .mem_rdata  (mem_rdata),
    .mem_wdata  (mem_wdata),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line 8 (0x20..0x23) holds 1,2,3,4; every other word holds 0xA000 | its address.
  function automatic logic [63:0] init_line(input int i);
    logic [63:0] l;
    if (i == 8) return {16'd4, 16'd3, 16'd2, 16'd1};
    for (int k = 0; k < 4; k++) l[16*k +: 16] = 16'hA000 | 16'(4*i + k);
    return l;
  endfunction

  logic [63:0] mem [64];
  logic        mem_init;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_line(i);
    end else begin
      if (readM)  mem_rdata <= mem[address[7:2]];
      if (writeM) mem[address[7:2]] <= mem_wdata;
    end
  end

  int n_applied = 0;
  int n_fail    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  int          r_lat, r_nread, r_nwrite;
  logic [15:0] r_raddr, r_waddr, r_rdata;
  logic [63:0] r_wline;
  logic        r_both;

  task automatic run_access(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    int c;
    r_lat = -1; r_nread = 0; r_nwrite = 0; r_both = 1'b0;
    r_raddr = '0; r_waddr = '0; r_wline = '0; r_rdata = '0;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    c = 0;
    while (r_lat < 0 && c < 40) begin
      @(negedge clk);
      if (readM)  begin r_nread++;  r_raddr = address; end
      if (writeM) begin r_nwrite++; r_waddr = address; r_wline = mem_wdata; end
      if (readM && writeM) r_both = 1'b1;
      if (cpu_ready) begin r_lat = c; r_rdata = cpu_rdata; end
      c++;
    end
    if (r_lat < 0) begin
      n_applied++; n_fail++;
      $display("FAIL timeout: no cpu_ready within 40 cycles for addr %h", addr);
    end else begin
      @(posedge clk); #1;
    end
    cpu_req = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr, wdata;
    int          lat, nread, nwrite;
    logic [15:0] raddr, waddr;
    logic [63:0] wline;
    logic [15:0] rdata, hits, misses;
  } vec_t;

  vec_t vecs[10];
  logic idle_act;

  initial begin
    vecs[0] = '{1'b0, 16'h0023, 16'h0000, 3, 2, 0, 16'h0020, 16'h0000, 64'h0, 16'h0004, 16'd0, 16'd1};
    vecs[1] = '{1'b0, 16'h0021, 16'h0000, 1, 0, 0, 16'h0000, 16'h0000, 64'h0, 16'h0002, 16'd1, 16'd1};
    vecs[2] = '{1'b1, 16'h0022, 16'hBEEF, 1, 0, 0, 16'h0000, 16'h0000, 64'h0, 16'h0000, 16'd2, 16'd1};
    vecs[3] = '{1'b0, 16'h0022, 16'h0000, 1, 0, 0, 16'h0000, 16'h0000, 64'h0, 16'hBEEF, 16'd3, 16'd1};
    vecs[4] = '{1'b0, 16'h0040, 16'h0000, 5, 2, 2, 16'h0040, 16'h0020,
                64'h0004_BEEF_0002_0001, 16'hA040, 16'd3, 16'd2};
    vecs[5] = '{1'b1, 16'h0085, 16'h1234, 3, 2, 0, 16'h0084, 16'h0000, 64'h0, 16'h0000, 16'd3, 16'd3};
    vecs[6] = '{1'b0, 16'h0085, 16'h0000, 1, 0, 0, 16'h0000, 16'h0000, 64'h0, 16'h1234, 16'd4, 16'd3};
    vecs[7] = '{1'b0, 16'h00A4, 16'h0000, 5, 2, 2, 16'h00A4, 16'h0084,
                64'hA087_A086_1234_A084, 16'hA0A4, 16'd4, 16'd4};
    vecs[8] = '{1'b0, 16'h0020, 16'h0000, 3, 2, 0, 16'h0020, 16'h0000, 64'h0, 16'h0001, 16'd4, 16'd5};
    vecs[9] = '{1'b0, 16'h0022, 16'h0000, 1, 0, 0, 16'h0000, 16'h0000, 64'h0, 16'hBEEF, 16'd5, 16'd5};

    reset_n = 1'b0; mem_init = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1; mem_init = 1'b0;

    @(negedge clk);
    chk("reset_readM", readM, 1'b0);
    chk("reset_writeM", writeM, 1'b0);
    chk("reset_ready", cpu_ready, 1'b0);
    chk("reset_address", address, 16'h0);
    chk("reset_rdata", cpu_rdata, 16'h0);
    chk("reset_hits", hit_count, 16'd0);
    chk("reset_misses", miss_count, 16'd0);

    for (int i = 0; i < 10; i++) begin
      run_access(vecs[i].we, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("v%0d_latency", i), r_lat, vecs[i].lat);
      chk($sformatf("v%0d_readM_cycles", i), r_nread, vecs[i].nread);
      chk($sformatf("v%0d_writeM_cycles", i), r_nwrite, vecs[i].nwrite);
      chk($sformatf("v%0d_rw_exclusive", i), r_both, 1'b0);
      if (vecs[i].nread > 0) chk($sformatf("v%0d_read_addr", i), r_raddr, vecs[i].raddr);
      if (vecs[i].nwrite > 0) begin
        chk($sformatf("v%0d_write_addr", i), r_waddr, vecs[i].waddr);
        chk($sformatf("v%0d_write_line", i), r_wline, vecs[i].wline);
      end
      if (!vecs[i].we) chk($sformatf("v%0d_rdata", i), r_rdata, vecs[i].rdata);
      chk($sformatf("v%0d_hit_count", i), hit_count, vecs[i].hits);
      chk($sformatf("v%0d_miss_count", i), miss_count, vecs[i].misses);
    end

    idle_act = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (readM || writeM || cpu_ready) idle_act = 1'b1;
    end
    chk("idle_activity", idle_act, 1'b0);
    chk("idle_hits", hit_count, 16'd5);
    chk("idle_misses", miss_count, 16'd5);

    // Reset lands on the edge that would have captured the fill line.
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    repeat (3) @(negedge clk);
    chk("rst_fill_readM_before", readM, 1'b1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(negedge clk);
    chk("rst_fill_readM", readM, 1'b0);
    chk("rst_fill_ready", cpu_ready, 1'b0);
    chk("rst_fill_hits", hit_count, 16'd0);
    chk("rst_fill_misses", miss_count, 16'd0);
    chk("rst_fill_rdata", cpu_rdata, 16'h0);
    reset_n = 1'b1;

    run_access(1'b0, 16'h0021, 16'h0000);
    chk("post_rst_latency", r_lat, 3);
    chk("post_rst_readM_cycles", r_nread, 2);
    chk("post_rst_rdata", r_rdata, 16'h0002);
    chk("post_rst_hits", hit_count, 16'd0);
    chk("post_rst_misses", miss_count, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
    $finish;
  end

endmodule
